// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding for the sub-word read-modify-write sequence
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LSU_IDLE  = 1'b0,
    LSU_WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_load_align.sv
// lsu_load_align: purely combinational lane select and sign/zero extension
// of a 32-bit little-endian memory word.
//   word   : raw memory word
//   lane   : byte address bits [1:0]
//   funct3 : RV32I load width/sign code
//   data   : extended result (0 for codes that are not loads)
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfwords are only legal on even lanes, so lane[1] picks the half.
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_H:    data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(WIDTH-16){1'b0}}, half_sel};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute-stage byte address to a word-indexed
// data memory (combinational read, write at clock edge, no byte enables).
//   clk, reset            : clock, asynchronous active-high reset
//   mem_en, is_store      : access request and direction
//   funct3, addr          : RV32I width code and byte address
//   store_data            : rs2 value
//   load_data             : extended load result
//   stall                 : core holds PC/inputs while high (SB/SH first cycle)
//   fault, fault_addr     : illegal/misaligned access and its captured address
//   dm_addr, dm_wdata     : word index and write word to memory
//   dm_write, dm_read     : memory strobes (never both high)
//   dm_rdata              : memory read word
// SB/SH are done as read-modify-write: the IDLE cycle reads and merges into
// merge_reg, the WRITE cycle writes merge_reg back to held_idx.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  store_data,
  output logic [WIDTH-1:0]  load_data,
  output logic              stall,
  output logic              fault,
  output logic [WIDTH-1:0]  fault_addr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [WIDTH-1:0]  dm_wdata,
  output logic              dm_write,
  output logic              dm_read,
  input  logic [WIDTH-1:0]  dm_rdata
);

  lsu_state_t        state, state_n;
  logic [WIDTH-1:0]  merge_reg;
  logic [ADDR_W-1:0] held_idx;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              illegal;
  logic              misaligned;
  logic              load_en;
  logic              capture;
  logic              fault_cap;
  logic [WIDTH-1:0]  merged;
  logic [WIDTH-1:0]  aligned_data;

  assign idx  = addr[ADDR_W+1:2];
  assign lane = addr[1:0];

  // Access legality and alignment
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = is_store;
      default:          illegal = 1'b1;
    endcase

    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = lane[0];
      F3_W:        misaligned = (lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Sub-word merge of store_data into the word currently read from memory
  always_comb begin
    merged = dm_rdata;
    if (funct3 == F3_B) begin
      case (lane)
        2'd0: merged[7:0]   = store_data[7:0];
        2'd1: merged[15:8]  = store_data[7:0];
        2'd2: merged[23:16] = store_data[7:0];
        2'd3: merged[31:24] = store_data[7:0];
        default: merged = dm_rdata;
      endcase
    end else begin
      if (lane[1]) merged[31:16] = store_data[15:0];
      else         merged[15:0]  = store_data[15:0];
    end
  end

  lsu_load_align #(.WIDTH(WIDTH)) u_align (
    .word   (dm_rdata),
    .lane   (lane),
    .funct3 (funct3),
    .data   (aligned_data)
  );

  // Next-state and outputs; everything is forced quiet while reset is high.
  always_comb begin
    state_n   = state;
    dm_read   = 1'b0;
    dm_write  = 1'b0;
    stall     = 1'b0;
    fault     = 1'b0;
    dm_addr   = idx;
    dm_wdata  = store_data;
    load_en   = 1'b0;
    capture   = 1'b0;
    fault_cap = 1'b0;

    if (!reset) begin
      case (state)
        LSU_IDLE: begin
          if (mem_en) begin
            if (illegal || misaligned) begin
              fault     = 1'b1;
              fault_cap = 1'b1;
            end else if (!is_store) begin
              dm_read = 1'b1;
              load_en = 1'b1;
            end else if (funct3 == F3_W) begin
              dm_write = 1'b1;
            end else begin
              dm_read = 1'b1;
              stall   = 1'b1;
              capture = 1'b1;
              state_n = LSU_WRITE;
            end
          end
        end
        LSU_WRITE: begin
          dm_addr  = held_idx;
          dm_wdata = merge_reg;
          dm_write = 1'b1;
          state_n  = LSU_IDLE;
        end
        default: state_n = LSU_IDLE;
      endcase
    end
  end

  assign load_data = load_en ? aligned_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LSU_IDLE;
      merge_reg  <= '0;
      held_idx   <= '0;
      fault_addr <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        merge_reg <= merged;
        held_idx  <= idx;
      end
      if (fault_cap) fault_addr <= addr;
    end
  end

endmodule
